led_blink_arbiter: RTL and testbench

Time-shares the single board LED between up to N_REQ requesters. Each requester signals a condition by showing a short blink code: a count of pulses followed by a gap. The block grants the LED to one requester at a time in round-robin order and plays that requester's code from a prescaled blink tick. It sits in the CPLD top level between the status sources and the `led` pin, replacing a direct counter-bit drive.

---
 rtl/led_blink_arbiter.sv | 144 ++++++++++++++
 tb/tb_led_blink_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that time-shares one LED between requesters, playing the
// granted requester's blink code (N pulses, then a two-unit gap) off a prescaled tick.
module led_blink_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CODE_W   = 3,
  parameter int unsigned TICK_DIV = 2**21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CODE_W-1:0]  code,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     led
);

  localparam int unsigned PtrW  = $clog2(N_REQ);
  localparam int unsigned PresW = $clog2(TICK_DIV);
  localparam logic [PresW-1:0] TickMax = PresW'(TICK_DIV - 1);
  localparam logic [PtrW-1:0]  PtrMax  = PtrW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e              state_q, state_d;
  logic [PresW-1:0]    presc_q, presc_d;
  logic [CODE_W-1:0]   pc_q, pc_d;
  logic                gap_q, gap_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                busy_q, busy_d;
  logic                led_q, led_d;

  logic                tick;
  logic [PtrW-1:0]     win;
  logic [CODE_W-1:0]   win_code;

  // Lowest set bit at or above ptr wins; otherwise the lowest set bit below ptr.
  always_comb begin
    win = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(ptr_q))) win = PtrW'(i);
    end
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr_q))) win = PtrW'(i);
    end
  end

  always_comb begin
    win_code = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (PtrW'(i) == win) win_code = code[i*CODE_W +: CODE_W];
    end
  end

  assign tick = (state_q != StIdle) && (presc_q == TickMax);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pc_d    = pc_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;

    if (state_q != StIdle) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req != '0) begin
          gnt_d   = N_REQ'(1) << win;
          pc_d    = win_code;
          ptr_d   = (win == PtrMax) ? '0 : win + 1'b1;
          presc_d = '0;
          gap_d   = 1'b0;
          state_d = (win_code != '0) ? StOn : StGap;
        end
      end
      StOn: begin
        if (tick) begin
          pc_d    = pc_q - 1'b1;
          state_d = StOff;
        end
      end
      StOff: begin
        if (tick) begin
          gap_d   = 1'b0;
          state_d = (pc_q != '0) ? StOn : StGap;
        end
      end
      StGap: begin
        if (tick) begin
          if (gap_q) begin
            gnt_d   = '0;
            done_d  = gnt_q;
            state_d = StIdle;
          end else begin
            gap_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state change.
  always_comb begin
    led_d  = (state_d == StOn);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      pc_q    <= '0;
      gap_q   <= 1'b0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pc_q    <= pc_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Bench for led_blink_arbiter: elapsed-time playback model plus directed and random scenarios.
module tb_led_blink_arbiter;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int T  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] code = '0;
  logic [N-1:0]    gnt, done;
  logic            busy, led;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: playback described by elapsed cycles since the grant.
  logic         m_active = 1'b0;
  int           m_owner = 0;
  int           m_code = 0;
  int           m_k = 0;
  int           m_ptr = 0;
  logic [N-1:0] m_done = '0;

  led_blink_arbiter #(.N_REQ(N), .CODE_W(CW), .TICK_DIV(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code),
    .gnt(gnt), .done(done), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++) if (r[(p + j) % N]) return (p + j) % N;
    return 0;
  endfunction

  // {led, busy, done, gnt} expected after the most recent edge.
  function automatic logic [2*N+1:0] exp_vec();
    logic l;
    l = m_active && (m_k < 2 * m_code * T) && (((m_k / T) % 2) == 0);
    return {l, m_active, m_done, m_active ? N'(1 << m_owner) : N'(0)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_ptr    <= 0;
      m_done   <= '0;
      m_owner  <= 0;
      m_code   <= 0;
    end else begin
      m_done <= '0;
      if (m_active) begin
        if (m_k + 1 == (2 * m_code + 2) * T) begin
          m_active <= 1'b0;
          m_done   <= N'(1 << m_owner);
        end else begin
          m_k <= m_k + 1;
        end
      end else if (req != '0) begin
        m_active <= 1'b1;
        m_owner  <= pick(req, m_ptr);
        m_code   <= int'(code[pick(req, m_ptr)*CW +: CW]);
        m_k      <= 0;
        m_ptr    <= (pick(req, m_ptr) + 1) % N;
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && !m_active) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    req   = 4'b1111;
    code  = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold got=%b want=0", {led, busy, done, gnt});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_gnt got=%b want=0001", gnt);
    end
    req = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_play c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
    end
    wait_idle(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reset_idle timeout busy=%b", busy);
    end
  endtask

  task automatic test_single();
    int led_hi, gnt_hi, done_n, busy_hi;
    led_hi = 0; gnt_hi = 0; done_n = 0; busy_hi = 0;
    code = '0;
    code[0 +: CW] = 3'd2;
    req = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) req = '0;
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL single c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
      led_hi  += int'(led);
      gnt_hi  += int'(gnt[0]);
      done_n  += int'(done[0]);
      busy_hi += int'(busy);
    end
    vectors += 4;
    if (led_hi != 8)   begin miscompares++; $display("FAIL single_led got=%0d want=8", led_hi); end
    if (gnt_hi != 24)  begin miscompares++; $display("FAIL single_gnt got=%0d want=24", gnt_hi); end
    if (done_n != 1)   begin miscompares++; $display("FAIL single_done got=%0d want=1", done_n); end
    if (busy_hi != 24) begin miscompares++; $display("FAIL single_busy got=%0d want=24", busy_hi); end
  endtask

  task automatic test_zero_code();
    int led_hi, gnt_hi, done_n;
    led_hi = 0; gnt_hi = 0; done_n = 0;
    code = '0;
    req  = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) req = '0;
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL zero c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
      led_hi += int'(led);
      gnt_hi += int'(gnt[1]);
      done_n += int'(done[1]);
    end
    vectors += 3;
    if (led_hi != 0) begin miscompares++; $display("FAIL zero_led got=%0d want=0", led_hi); end
    if (gnt_hi != 8) begin miscompares++; $display("FAIL zero_gnt got=%0d want=8", gnt_hi); end
    if (done_n != 1) begin miscompares++; $display("FAIL zero_done got=%0d want=1", done_n); end
  endtask

  task automatic test_round_robin();
    int           order[$];
    int           exp_order[6];
    logic [N-1:0] prev;
    bit           ok;
    exp_order = '{0, 1, 2, 3, 1, 3};
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) code[i*CW +: CW] = CW'($urandom_range(0, 2));
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    prev = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rr c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
      if (prev == '0 && gnt != '0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
        if (order.size() == 4) req = 4'b1010;
        if (order.size() == 6) req = '0;
      end
      prev = gnt;
      if (order.size() == 6 && !busy && !m_active) break;
    end
    vectors++;
    if (order.size() != 6) begin
      miscompares++;
      $display("FAIL rr_count got=%0d want=6", order.size());
    end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      vectors++;
      if (order[i] != exp_order[i]) begin
        miscompares++;
        $display("FAIL rr_order i=%0d got=%0d want=%0d", i, order[i], exp_order[i]);
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_mid_change();
    int led_hi, gnt_hi, done_n;
    led_hi = 0; gnt_hi = 0; done_n = 0;
    code = '0;
    code[2*CW +: CW] = 3'd3;
    req = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) begin
        req = '0;
        code[2*CW +: CW] = 3'd0;
      end
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
      led_hi += int'(led);
      gnt_hi += int'(gnt[2]);
      done_n += int'(done[2]);
    end
    vectors += 3;
    if (led_hi != 12) begin miscompares++; $display("FAIL mid_led got=%0d want=12", led_hi); end
    if (gnt_hi != 32) begin miscompares++; $display("FAIL mid_gnt got=%0d want=32", gnt_hi); end
    if (done_n != 1)  begin miscompares++; $display("FAIL mid_done got=%0d want=1", done_n); end
  endtask

  task automatic test_reset_mid();
    code = '0;
    code[2*CW +: CW] = 3'd2;
    req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rmid_pre c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({led, busy, done, gnt} !== '0) begin
      miscompares++;
      $display("FAIL rmid_async got=%b want=0", {led, busy, done, gnt});
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== '0) begin
        miscompares++;
        $display("FAIL rmid_hold got=%b want=0", {led, busy, done, gnt});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL rmid_regrant got=%b want=0100", gnt);
    end
    req = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rmid_post c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      vectors++;
      if ({led, busy, done, gnt} !== exp_vec()) begin
        miscompares++;
        $display("FAIL rand c=%0d got=%b want=%b", c, {led, busy, done, gnt}, exp_vec());
      end
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) code = (N*CW)'($urandom);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_zero_code();
    test_round_robin();
    test_mid_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
